s4ga_cfg_seq: RTL and testbench

Configuration sequencer for the s4ga LUT fabric. It holds one packed configuration entry per LUT in an internal register file, loaded through a host write port. It replays the entries as the fabric's SI_W-bit segment stream, one segment per clock, and drives the fabric's synchronous reset. It sits between the host/test logic and the fabric's {si,rst} inputs, and it owns starting, stopping and frame counting of fabric evaluation.

---
 rtl/s4ga_cfg_seq_if.sv | 39 +++
 rtl/s4ga_cfg_seq.sv | 171 +++++++++++++++++
 tb/tb_s4ga_cfg_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/s4ga_cfg_seq_if.sv
// Host-side bundle for the s4ga configuration sequencer: the config write
// port, the run controls, and the segment stream / status returned to the host.
interface s4ga_cfg_seq_if #(
   parameter int N      = 16,
   parameter int K      = 4,
   parameter int SI_W   = 4,
   parameter int FCNT_W = 16
) ();
   localparam int IDX_W     = $clog2(N);
   localparam int IDX_SEGS  = (IDX_W + SI_W - 1) / SI_W;
   localparam int MASK_SEGS = ((2 ** K) + SI_W - 1) / SI_W;
   localparam int CFG_SEGS  = K * IDX_SEGS + MASK_SEGS;
   localparam int CFG_W     = CFG_SEGS * SI_W;

   logic              wr_en;
   logic [IDX_W-1:0]  wr_addr;
   logic [CFG_W-1:0]  wr_data;
   logic              start;
   logic [FCNT_W-1:0] run_frames;
   logic              stop;
   logic [SI_W-1:0]   si;
   logic              fab_rst;
   logic              busy;
   logic [IDX_W-1:0]  lut_n;
   logic              frame_done;
   logic [FCNT_W-1:0] frame_cnt;

   // Host / test logic side.
   modport master (
      output wr_en, wr_addr, wr_data, start, run_frames, stop,
      input  si, fab_rst, busy, lut_n, frame_done, frame_cnt
   );

   // Sequencer side.
   modport slave (
      input  wr_en, wr_addr, wr_data, start, run_frames, stop,
      output si, fab_rst, busy, lut_n, frame_done, frame_cnt
   );
endinterface

// File: rtl/s4ga_cfg_seq.sv
// s4ga configuration sequencer: holds one packed config entry per LUT and
// replays them as a seamless SI_W-bit segment stream into the fabric, owning
// fabric reset, run start/stop and frame counting. Every output is registered.
module s4ga_cfg_seq #(
   parameter int N      = 16,
   parameter int K      = 4,
   parameter int SI_W   = 4,
   parameter int FCNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   s4ga_cfg_seq_if.slave    bus
);
   localparam int IDX_W     = $clog2(N);
   localparam int IDX_SEGS  = (IDX_W + SI_W - 1) / SI_W;
   localparam int MASK_SEGS = ((2 ** K) + SI_W - 1) / SI_W;
   localparam int CFG_SEGS  = K * IDX_SEGS + MASK_SEGS;
   localparam int CFG_W     = CFG_SEGS * SI_W;
   localparam int SEG_W     = (CFG_SEGS > 1) ? $clog2(CFG_SEGS) : 1;

   localparam logic [SEG_W-1:0]  SEG_LAST = SEG_W'(CFG_SEGS - 1);
   localparam logic [IDX_W-1:0]  LUT_LAST = IDX_W'(N - 1);
   localparam logic [FCNT_W-1:0] CNT_MAX  = {FCNT_W{1'b1}};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Config store (deliberately not reset) and sequencing state.
   logic [CFG_W-1:0]  mem_r [N];
   state_t            state_r,      state_s;
   logic [SEG_W-1:0]  seg_r,        seg_s;
   logic [CFG_W-1:0]  shreg_r,      shreg_s;
   logic [FCNT_W-1:0] run_frames_r, run_frames_s;
   logic              stop_pend_r,  stop_pend_s;
   logic [SI_W-1:0]   si_r,         si_s;
   logic              fab_rst_r,    fab_rst_s;
   logic              busy_r,       busy_s;
   logic [IDX_W-1:0]  lut_r,        lut_s;
   logic              frame_done_r, frame_done_s;
   logic [FCNT_W-1:0] frame_cnt_r,  frame_cnt_s;
   logic [IDX_W-1:0]  lut_inc_s;
   logic              stop_req_s;
   logic              limit_hit_s;

   // Host writes land in the store in any state, even while rst is asserted.
   always_ff @(posedge clk) begin
      if (bus.wr_en) begin
         mem_r[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Next-state and next-output logic; the snapshot reads the store before a
   // same-edge write lands, so a write racing its snapshot shows up next frame.
   always_comb begin
      state_s      = state_r;
      seg_s        = seg_r;
      shreg_s      = shreg_r;
      run_frames_s = run_frames_r;
      stop_pend_s  = stop_pend_r;
      si_s         = si_r;
      fab_rst_s    = fab_rst_r;
      busy_s       = busy_r;
      lut_s        = lut_r;
      frame_done_s = 1'b0;
      frame_cnt_s  = frame_cnt_r;
      lut_inc_s    = (lut_r == LUT_LAST) ? {IDX_W{1'b0}} : lut_r + IDX_W'(1);
      stop_req_s   = stop_pend_r | bus.stop;
      limit_hit_s  = (run_frames_r != {FCNT_W{1'b0}}) && (frame_cnt_r == run_frames_r);

      case (state_r)
         ST_IDLE: begin
            fab_rst_s   = 1'b1;
            si_s        = {SI_W{1'b0}};
            busy_s      = 1'b0;
            lut_s       = {IDX_W{1'b0}};
            seg_s       = {SEG_W{1'b0}};
            stop_pend_s = 1'b0;
            if (bus.start) begin
               state_s      = ST_RUN;
               run_frames_s = bus.run_frames;
               frame_cnt_s  = {FCNT_W{1'b0}};
               shreg_s      = mem_r[0] << SI_W;
               si_s         = mem_r[0][CFG_W-1 -: SI_W];
               fab_rst_s    = 1'b0;
               busy_s       = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (seg_r != SEG_LAST) begin
               // Mid-entry: shift the next segment out of the snapshot.
               seg_s       = seg_r + SEG_W'(1);
               si_s        = shreg_r[CFG_W-1 -: SI_W];
               shreg_s     = shreg_r << SI_W;
               stop_pend_s = stop_req_s;
               if ((seg_s == SEG_LAST) && (lut_r == LUT_LAST)) begin
                  frame_done_s = 1'b1;
                  frame_cnt_s  = (frame_cnt_r == CNT_MAX) ? frame_cnt_r
                                                          : frame_cnt_r + FCNT_W'(1);
               end else begin
                  frame_done_s = 1'b0;
               end
            end else if ((lut_r == LUT_LAST) && (stop_req_s || limit_hit_s)) begin
               // Frame boundary with a stop pending or the frame budget spent.
               state_s     = ST_IDLE;
               fab_rst_s   = 1'b1;
               si_s        = {SI_W{1'b0}};
               busy_s      = 1'b0;
               lut_s       = {IDX_W{1'b0}};
               seg_s       = {SEG_W{1'b0}};
               stop_pend_s = 1'b0;
            end else begin
               // Entry boundary: snapshot the next LUT with no bubble.
               seg_s       = {SEG_W{1'b0}};
               lut_s       = lut_inc_s;
               shreg_s     = mem_r[lut_inc_s] << SI_W;
               si_s        = mem_r[lut_inc_s][CFG_W-1 -: SI_W];
               stop_pend_s = stop_req_s;
            end
         end
         default: begin
            state_s     = ST_IDLE;
            fab_rst_s   = 1'b1;
            si_s        = {SI_W{1'b0}};
            busy_s      = 1'b0;
            lut_s       = {IDX_W{1'b0}};
            seg_s       = {SEG_W{1'b0}};
            stop_pend_s = 1'b0;
         end
      endcase
   end

   // State and output registers; rst abandons any partial frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         seg_r        <= {SEG_W{1'b0}};
         shreg_r      <= {CFG_W{1'b0}};
         run_frames_r <= {FCNT_W{1'b0}};
         stop_pend_r  <= 1'b0;
         si_r         <= {SI_W{1'b0}};
         fab_rst_r    <= 1'b1;
         busy_r       <= 1'b0;
         lut_r        <= {IDX_W{1'b0}};
         frame_done_r <= 1'b0;
         frame_cnt_r  <= {FCNT_W{1'b0}};
      end else begin
         state_r      <= state_s;
         seg_r        <= seg_s;
         shreg_r      <= shreg_s;
         run_frames_r <= run_frames_s;
         stop_pend_r  <= stop_pend_s;
         si_r         <= si_s;
         fab_rst_r    <= fab_rst_s;
         busy_r       <= busy_s;
         lut_r        <= lut_s;
         frame_done_r <= frame_done_s;
         frame_cnt_r  <= frame_cnt_s;
      end
   end

   assign bus.si         = si_r;
   assign bus.fab_rst    = fab_rst_r;
   assign bus.busy       = busy_r;
   assign bus.lut_n      = lut_r;
   assign bus.frame_done = frame_done_r;
   assign bus.frame_cnt  = frame_cnt_r;
endmodule

// File: tb/tb_s4ga_cfg_seq.sv
// Bench for s4ga_cfg_seq: a frame-position model predicts every output each
// cycle; predictions are queued when stimulus is driven and compared after
// the edge, plus directed checks on pulse counts, spacing and run lengths.
module tb_s4ga_cfg_seq;
   localparam int N      = 16;
   localparam int FRAME  = 128;
   localparam int SEGS   = 8;

   logic clk;
   logic rst;

   s4ga_cfg_seq_if #(.N(16), .K(4), .SI_W(4), .FCNT_W(16)) bus ();

   s4ga_cfg_seq #(.N(16), .K(4), .SI_W(4), .FCNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp;
   int          n_err;
   int          cyc;
   int          fd_seen;
   int          busy_cycles;
   int          fd_prev;
   logic [26:0] exp_q [$];

   // Model state.
   logic [31:0] m_mem [N];
   logic [31:0] m_snap;
   bit          m_run;
   int          m_k;
   logic [15:0] m_cnt;
   logic [15:0] m_rf;
   bit          m_stop;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
      n_cmp++;
      if (obs !== req) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, obs, req);
      end
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step(output logic [26:0] e);
      if (rst) begin
         m_run  = 1'b0;
         m_k    = 0;
         m_cnt  = 16'd0;
         m_stop = 1'b0;
      end else if (!m_run) begin
         if (bus.start) begin
            m_run  = 1'b1;
            m_rf   = bus.run_frames;
            m_cnt  = 16'd0;
            m_k    = 0;
            m_stop = 1'b0;
            m_snap = m_mem[0];
         end
      end else begin
         if (bus.stop) m_stop = 1'b1;
         if (m_k == FRAME - 1) begin
            if (m_stop || (m_rf != 16'd0 && m_cnt == m_rf)) begin
               m_run  = 1'b0;
               m_stop = 1'b0;
               m_k    = 0;
            end else begin
               m_k    = 0;
               m_snap = m_mem[0];
            end
         end else begin
            m_k = m_k + 1;
            if (m_k % SEGS == 0) m_snap = m_mem[m_k / SEGS];
            if (m_k == FRAME - 1 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         end
      end
      if (bus.wr_en) m_mem[bus.wr_addr] = bus.wr_data;
      if (m_run)
         e = {1'b0, 1'b1, (m_k == FRAME - 1), 4'(m_k / SEGS),
              m_snap[31 - 4 * (m_k % SEGS) -: 4], m_cnt};
      else
         e = {1'b1, 1'b0, 1'b0, 4'd0, 4'd0, m_cnt};
   endtask

   // One clock: predict, push, clock, pop and compare, drop pulse inputs.
   task automatic tick();
      logic [26:0] e;
      logic [26:0] o;
      model_step(e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      o = {bus.fab_rst, bus.busy, bus.frame_done, bus.lut_n, bus.si, bus.frame_cnt};
      chk("outputs", {37'd0, o}, {37'd0, exp_q.pop_front()});
      if (bus.busy === 1'b1) busy_cycles++;
      if (bus.frame_done === 1'b1) begin
         fd_seen++;
         if (fd_prev >= 0) chk("fd_gap", 64'(cyc - fd_prev), 64'd128);
         fd_prev = cyc;
      end
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.wr_en = 1'b0;
   endtask

   task automatic begin_run(input logic [15:0] frames);
      fd_seen     = 0;
      busy_cycles = 0;
      fd_prev     = -1;
      bus.start      = 1'b1;
      bus.run_frames = frames;
      tick();
   endtask

   task automatic run_until_idle(input int max);
      int i;
      i = 0;
      while (bus.busy === 1'b1 && i < max) begin
         tick();
         i++;
      end
      chk("to_idle", {63'd0, bus.busy}, 64'd0);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      cyc   = 0;
      fd_prev = -1;
      for (int i = 0; i < N; i++) m_mem[i] = 32'd0;
      m_snap = 32'd0;
      m_run  = 1'b0;
      m_k    = 0;
      m_cnt  = 16'd0;
      m_rf   = 16'd0;
      m_stop = 1'b0;
      rst            = 1'b1;
      bus.wr_en      = 1'b0;
      bus.wr_addr    = 4'd0;
      bus.wr_data    = 32'd0;
      bus.start      = 1'b0;
      bus.run_frames = 16'd0;
      bus.stop       = 1'b0;

      // Reset state, with the store loaded while rst is held.
      tick();
      for (int i = 0; i < N; i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_addr = 4'(i);
         bus.wr_data = (i == 0) ? 32'h1234ABCD : (i == 1) ? 32'h0000FFFF : 32'd0;
         tick();
      end
      rst = 1'b0;
      tick();

      // Single-frame run.
      begin_run(16'd1);
      run_until_idle(200);
      chk("run1_fd", 64'(fd_seen), 64'd1);
      chk("run1_len", 64'(busy_cycles), 64'd128);
      chk("run1_cnt", {48'd0, bus.frame_cnt}, 64'd1);

      // Free run with an early stop.
      begin_run(16'd0);
      for (int i = 0; i < 49; i++) tick();
      bus.stop = 1'b1;
      tick();
      run_until_idle(200);
      chk("run2_fd", 64'(fd_seen), 64'd1);
      chk("run2_cnt", {48'd0, bus.frame_cnt}, 64'd1);

      // Free run, ignored start mid-run, stop coincident with frame_done.
      begin_run(16'd0);
      for (int i = 0; i < 99; i++) tick();
      bus.start      = 1'b1;
      bus.run_frames = 16'd5;
      tick();
      for (int i = 0; i < 155; i++) tick();
      chk("fd_at_256", {63'd0, bus.frame_done}, 64'd1);
      bus.stop = 1'b1;
      tick();
      run_until_idle(10);
      chk("run3_cnt", {48'd0, bus.frame_cnt}, 64'd2);
      chk("run3_len", 64'(busy_cycles), 64'd256);

      // Idle stop is ignored; then a 3-frame run with a racing write to LUT 5.
      bus.stop = 1'b1;
      tick();
      tick();
      begin_run(16'd3);
      for (int i = 0; i < 39; i++) tick();
      bus.wr_en   = 1'b1;
      bus.wr_addr = 4'd5;
      bus.wr_data = 32'hFFFFFFFF;
      tick();
      run_until_idle(500);
      chk("run4_fd", 64'(fd_seen), 64'd3);
      chk("run4_len", 64'(busy_cycles), 64'd384);
      chk("run4_cnt", {48'd0, bus.frame_cnt}, 64'd3);

      // Reset mid-run, then restart with retained store contents.
      begin_run(16'd0);
      for (int i = 0; i < 69; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_fd", 64'(fd_seen), 64'd0);
      tick();
      begin_run(16'd1);
      run_until_idle(200);
      chk("run5_fd", 64'(fd_seen), 64'd1);
      chk("run5_cnt", {48'd0, bus.frame_cnt}, 64'd1);
      chk("q_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
